// File: rtl/tt_ctrl_pkg.sv
// tt_ctrl_pkg -- shared definitions for the chip-level control path.
//   sel_state_e : project-selection FSM state encoding (also seen on state_o)
//   TT_ADDR_W   : default project select address width (shared with tt_top)
//   TT_N_PROJ   : default number of project slots (shared with tt_top)
//   cnt_w()     : bits needed to hold the values 0..n-1 (never less than 1)
package tt_ctrl_pkg;

   localparam int TT_ADDR_W = 10;
   localparam int TT_N_PROJ = 512;

   typedef enum logic [1:0] {
      S_CLEAR  = 2'b00,
      S_SELECT = 2'b01,
      S_GUARD  = 2'b10,
      S_ACTIVE = 2'b11
   } sel_state_e;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tt_ctrl_sync.sv
// tt_ctrl_sync -- single-bit pad input synchroniser with optional debounce.
// Optional feature macro: TT_SEL_DEBOUNCE_EN (adds a DEB_CYCLES sample filter).
// Ports:
//   clk   in  system clock
//   rst_n in  synchronous active-low reset (all flops load RST_VAL)
//   din   in  raw asynchronous pad level
//   dout  out synchronised (and, when enabled, debounced) level
module tt_ctrl_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter int   DEB_CYCLES  = 3,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   if (SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_bad_param
      $error("tt_ctrl_sync: SYNC_STAGES must be >= 2 and DEB_CYCLES >= 1");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;

   always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= {SYNC_STAGES{RST_VAL}};
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef TT_SEL_DEBOUNCE_EN
   // Counts consecutive samples that disagree with the filtered level; the
   // filtered level flips on the DEB_CYCLES-th disagreeing sample in a row.
   localparam int DCNT_W = tt_ctrl_pkg::cnt_w(DEB_CYCLES);

   logic [DCNT_W-1:0] deb_cnt;
   logic              deb_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         deb_q   <= RST_VAL;
         deb_cnt <= '0;
      end else if (sync_out == deb_q) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DCNT_W'(DEB_CYCLES - 1)) begin
         deb_q   <= sync_out;
         deb_cnt <= '0;
      end else begin
         deb_cnt <= deb_cnt + 1'b1;
      end
   end

   assign dout = deb_q;
`else
   assign dout = sync_out;
`endif

endmodule

// File: rtl/tt_mux_sel_ctrl.sv
// tt_mux_sel_ctrl -- project-selection sequencer for the control pads.
// Synchronises ctl[2:0], clears/steps the mux address, and enables the
// selected project after a guard delay. Optional macro TT_SEL_DEBOUNCE_EN
// inserts a debounce filter after each synchroniser.
// Ports:
//   clk, rst_n     in  clock, synchronous active-low reset
//   ctl_sel_rst_n  in  raw pad ctl[0]; low clears the selection
//   ctl_sel_inc    in  raw pad ctl[1]; rising edge increments the address
//   ctl_ena        in  raw pad ctl[2]; high requests project enable
//   sel_addr       out current project address (saturates at N_PROJ-1)
//   sel_stable     out address frozen (GUARD or ACTIVE)
//   proj_ena       out enable to the selected project
//   sel_ovf        out sticky: increment requested at N_PROJ-1
//   state_o        out FSM state for debug
module tt_mux_sel_ctrl
   import tt_ctrl_pkg::*;
#(
   parameter int ADDR_W       = TT_ADDR_W,
   parameter int N_PROJ       = TT_N_PROJ,
   parameter int SYNC_STAGES  = 2,
   parameter int GUARD_CYCLES = 4,
   parameter int DEB_CYCLES   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ctl_sel_rst_n,
   input  logic              ctl_sel_inc,
   input  logic              ctl_ena,
   output logic [ADDR_W-1:0] sel_addr,
   output logic              sel_stable,
   output logic              proj_ena,
   output logic              sel_ovf,
   output logic [1:0]        state_o
);

   if (GUARD_CYCLES < 1 || SYNC_STAGES < 2 || N_PROJ < 1 ||
       N_PROJ > (1 << ADDR_W)) begin : g_bad_param
      $error("tt_mux_sel_ctrl: illegal parameter combination");
   end

   localparam int                GCNT_W   = cnt_w(GUARD_CYCLES);
   localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(N_PROJ - 1);
   // Bit order matches the pad ring: [0] sel_rst_n, [1] inc, [2] ena.
   localparam logic [2:0]        SYNC_RST = 3'b000;

   logic [2:0] pad_raw, pad_sync;
   logic       sel_rst_s, inc_s, ena_s;

   assign pad_raw = {ctl_ena, ctl_sel_inc, ctl_sel_rst_n};

   for (genvar i = 0; i < 3; i++) begin : g_sync
      tt_ctrl_sync #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEB_CYCLES  (DEB_CYCLES),
         .RST_VAL     (SYNC_RST[i])
      ) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .din   (pad_raw[i]),
         .dout  (pad_sync[i])
      );
   end

   assign sel_rst_s = pad_sync[0];
   assign inc_s     = pad_sync[1];
   assign ena_s     = pad_sync[2];

   sel_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [GCNT_W-1:0] gcnt_q, gcnt_d;
   logic              ovf_q, ovf_d;
   logic              inc_prev_q, inc_pulse;
   logic              stable_q, ena_q;

   assign inc_pulse = inc_s & ~inc_prev_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      gcnt_d  = gcnt_q;
      ovf_d   = ovf_q;
      if (!sel_rst_s) begin
         state_d = S_CLEAR;
      end else begin
         case (state_q)
            S_CLEAR:  state_d = S_SELECT;
            S_SELECT: begin
               // Increment is applied before the ena check so a same-cycle
               // inc lands in the address that GUARD then freezes.
               if (inc_pulse) begin
                  if (addr_q < ADDR_MAX) addr_d = addr_q + 1'b1;
                  else                   ovf_d  = 1'b1;
               end
               if (ena_s) begin
                  gcnt_d  = GCNT_W'(GUARD_CYCLES - 1);
                  state_d = S_GUARD;
               end
            end
            S_GUARD: begin
               // Dropping ena wins over guard expiry in the same cycle.
               if (!ena_s)              state_d = S_SELECT;
               else if (gcnt_q == '0)   state_d = S_ACTIVE;
               else                     gcnt_d  = gcnt_q - 1'b1;
            end
            S_ACTIVE: if (!ena_s) state_d = S_SELECT;
            default:  state_d = S_CLEAR;
         endcase
      end
      // Entering (or staying in) CLEAR zeroes the selection on the same edge.
      if (state_d == S_CLEAR) begin
         addr_d = '0;
         ovf_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_CLEAR;
         addr_q     <= '0;
         gcnt_q     <= '0;
         ovf_q      <= 1'b0;
         inc_prev_q <= 1'b0;
         stable_q   <= 1'b0;
         ena_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         gcnt_q     <= gcnt_d;
         ovf_q      <= ovf_d;
         inc_prev_q <= inc_s;
         stable_q   <= (state_d == S_GUARD) || (state_d == S_ACTIVE);
         ena_q      <= (state_d == S_ACTIVE);
      end
   end

   assign sel_addr   = addr_q;
   assign sel_stable = stable_q;
   assign proj_ena   = ena_q;
   assign sel_ovf    = ovf_q;
   assign state_o    = state_q;

endmodule
